// File: rtl/on_the_fly_table_pkg.sv
// Shared field widths, default table depth and the entry tuple for the
// on-the-fly transaction table.
package on_the_fly_table_pkg;

  localparam int N_BIT_SRC_HEAD_FLIT  = 4;
  localparam int N_BIT_DEST_HEAD_FLIT = 4;
  localparam int N_BIT_CMD_HEAD_FLIT  = 3;
  localparam int OTF_TABLE_ENTRIES    = 8;

  // Identity of an outstanding transaction; two messages belong to the same
  // transaction when all three fields agree.
  typedef struct packed {
    logic [N_BIT_SRC_HEAD_FLIT-1:0]  sender;
    logic [N_BIT_DEST_HEAD_FLIT-1:0] recipient;
    logic [N_BIT_CMD_HEAD_FLIT-1:0]  cmd;
  } otf_entry_t;

  function automatic logic tuple_match(input otf_entry_t a, input otf_entry_t b);
    return a == b;
  endfunction

endpackage

// File: rtl/on_the_fly_table_first_one.sv
// Lowest-set-bit priority encoder: returns the index of the least
// significant set bit of vec_i and whether any bit is set.
module on_the_fly_table_first_one #(
  parameter int W     = 8,
  parameter int IDX_W = 3
) (
  input  logic [W-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/on_the_fly_table.sv
// Table of outstanding remote transactions. The request path inserts an
// entry when a request expecting a reply leaves; the receive path queries
// each arriving message, gets a registered hit flag one cycle later, and
// frees the hit entry with an executed pulse. Unanswered entries age out.
module on_the_fly_table
  import on_the_fly_table_pkg::*;
#(
  parameter int N_ENTRIES      = OTF_TABLE_ENTRIES,
  parameter int N_BITS_POINTER = 3,
  parameter int N_BITS_TIMEOUT = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            insert_i,
  input  logic [N_BIT_SRC_HEAD_FLIT-1:0]  insert_sender_i,
  input  logic [N_BIT_DEST_HEAD_FLIT-1:0] insert_recipient_i,
  input  logic [N_BIT_CMD_HEAD_FLIT-1:0]  insert_type_i,
  output logic                            full_o,
  input  logic                            query_i,
  input  logic [N_BIT_SRC_HEAD_FLIT-1:0]  query_sender_i,
  input  logic [N_BIT_DEST_HEAD_FLIT-1:0] query_recipient_i,
  input  logic [N_BIT_CMD_HEAD_FLIT-1:0]  transaction_type_i,
  output logic                            is_a_pending_transaction_o,
  input  logic                            pending_transaction_executed_i,
  output logic                            timeout_o,
  output logic                            error_o,
  output logic [N_BITS_POINTER:0]         n_pending_o
);

  localparam logic [N_BITS_TIMEOUT-1:0] AGE_LIMIT = N_BITS_TIMEOUT'(TIMEOUT_CYCLES - 1);
  localparam logic                      TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  logic [N_ENTRIES-1:0]      valid_q, valid_d;
  otf_entry_t                entry_q [N_ENTRIES];
  otf_entry_t                entry_d [N_ENTRIES];
  logic [N_BITS_TIMEOUT-1:0] age_q   [N_ENTRIES];
  logic [N_BITS_TIMEOUT-1:0] age_d   [N_ENTRIES];
  logic                      hit_valid_q, hit_valid_d;
  logic [N_BITS_POINTER-1:0] hit_idx_q, hit_idx_d;
  logic                      timeout_q, timeout_d;
  logic                      error_q, error_d;
  logic [N_BITS_POINTER:0]   n_pending_q, n_pending_d;

  logic [N_ENTRIES-1:0]      frozen_vec, freed_vec, expire_vec, match_vec;
  logic [N_BITS_POINTER-1:0] free_idx, match_idx;
  logic                      free_found, match_found;
  logic                      do_exec;
  otf_entry_t                insert_tuple, query_tuple;

  assign insert_tuple = '{sender: insert_sender_i, recipient: insert_recipient_i, cmd: insert_type_i};
  assign query_tuple  = '{sender: query_sender_i, recipient: query_recipient_i, cmd: transaction_type_i};
  assign do_exec      = pending_transaction_executed_i && hit_valid_q;

  // Classify each slot: held by the latched hit, freed by execute, expiring,
  // or matching the query. Lookup ignores slots that leave the table this edge.
  always_comb begin
    frozen_vec = '0;
    freed_vec  = '0;
    expire_vec = '0;
    match_vec  = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      frozen_vec[i] = hit_valid_q && (hit_idx_q == N_BITS_POINTER'(i));
      freed_vec[i]  = do_exec && (hit_idx_q == N_BITS_POINTER'(i));
      expire_vec[i] = TIMEOUT_EN && valid_q[i] && !frozen_vec[i] && (age_q[i] == AGE_LIMIT);
      match_vec[i]  = valid_q[i] && !freed_vec[i] && !expire_vec[i]
                      && tuple_match(entry_q[i], query_tuple);
    end
  end

  on_the_fly_table_first_one #(.W(N_ENTRIES), .IDX_W(N_BITS_POINTER)) u_alloc (
    .vec_i   (~valid_q),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  on_the_fly_table_first_one #(.W(N_ENTRIES), .IDX_W(N_BITS_POINTER)) u_lookup (
    .vec_i   (match_vec),
    .idx_o   (match_idx),
    .found_o (match_found)
  );

  // Next table contents: age, expire, free, allocate, latch lookup result.
  always_comb begin
    valid_d     = valid_q & ~freed_vec & ~expire_vec;
    entry_d     = entry_q;
    age_d       = age_q;
    hit_valid_d = hit_valid_q;
    hit_idx_d   = hit_idx_q;
    timeout_d   = |expire_vec;
    error_d     = pending_transaction_executed_i && !hit_valid_q;
    n_pending_d = '0;

    for (int i = 0; i < N_ENTRIES; i++) begin
      if (valid_q[i] && !frozen_vec[i] && (age_q[i] != '1)) begin
        age_d[i] = age_q[i] + N_BITS_TIMEOUT'(1);
      end
    end

    // full_o is derived from pre-edge state, so a slot freed this cycle is
    // not reusable until the next one.
    if (insert_i && free_found) begin
      valid_d[free_idx] = 1'b1;
      entry_d[free_idx] = insert_tuple;
      age_d[free_idx]   = '0;
    end

    if (query_i) begin
      hit_valid_d = match_found;
      hit_idx_d   = match_idx;
    end else if (do_exec) begin
      hit_valid_d = 1'b0;
    end

    for (int i = 0; i < N_ENTRIES; i++) begin
      n_pending_d = n_pending_d + (N_BITS_POINTER + 1)'(valid_d[i]);
    end
  end

  // Table state and registered outputs; reset drops every entry at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= '0;
      hit_valid_q <= 1'b0;
      hit_idx_q   <= '0;
      timeout_q   <= 1'b0;
      error_q     <= 1'b0;
      n_pending_q <= '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        entry_q[i] <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      hit_valid_q <= hit_valid_d;
      hit_idx_q   <= hit_idx_d;
      timeout_q   <= timeout_d;
      error_q     <= error_d;
      n_pending_q <= n_pending_d;
      for (int i = 0; i < N_ENTRIES; i++) begin
        entry_q[i] <= entry_d[i];
        age_q[i]   <= age_d[i];
      end
    end
  end

  assign full_o                     = !free_found;
  assign is_a_pending_transaction_o = hit_valid_q;
  assign timeout_o                  = timeout_q;
  assign error_o                    = error_q;
  assign n_pending_o                = n_pending_q;

endmodule

// File: doc/on_the_fly_table.md
# on_the_fly_table

Tracks outstanding remote transactions started by local WB masters so that the NoC-to-WB path can tell replies apart from fresh requests. Entries are inserted by the WB-to-NoC request path when a request that expects a reply leaves the node. The NoC-to-WB path queries the table for each arriving message. The table answers whether the message is a reply, and frees the entry once the reply has been executed on the bus; entries that wait too long time out.

## Interface
Parameters:
- N_ENTRIES, 8, number of table slots
- N_BITS_POINTER, 3, clog2(N_ENTRIES)
- N_BITS_TIMEOUT, 10, width of the per-entry age counter
- TIMEOUT_CYCLES, 1000, age at which an entry expires; 0 disables timeout

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- insert_i  in  1  request to allocate an entry
- insert_sender_i  in  `N_BIT_SRC_HEAD_FLIT  local node that issued the request
- insert_recipient_i  in  `N_BIT_DEST_HEAD_FLIT  remote node expected to reply
- insert_type_i  in  `N_BIT_CMD_HEAD_FLIT  command code of the request
- full_o  out  1  high when no slot is free
- query_i  in  1  NoC-to-WB path is querying
- query_sender_i  in  `N_BIT_SRC_HEAD_FLIT  local node addressed by the reply
- query_recipient_i  in  `N_BIT_DEST_HEAD_FLIT  remote node that generated the reply
- transaction_type_i  in  `N_BIT_CMD_HEAD_FLIT  command code carried by the message
- is_a_pending_transaction_o  out  1  registered hit result
- pending_transaction_executed_i  in  1  pulse: latched hit entry has been executed and acked
- timeout_o  out  1  one-cycle pulse: an entry expired and was freed
- error_o  out  1  one-cycle pulse: executed pulse arrived with no latched hit
- n_pending_o  out  N_BITS_POINTER+1  number of valid entries

## Operation
- Per entry: valid bit, sender, recipient, cmd, age counter.
- **Insert**
  - When insert_i && !full_o, the lowest-index free slot is written and set valid. Its age is cleared.
  - insert_i while full_o is ignored. The producer must hold the request.
- **Match**
  - A valid entry matches when sender, recipient and cmd are all equal to the query fields.
  - Duplicates are allowed. The lowest-index matching entry wins; identical tuples are interchangeable.
- **Query**
  - In each cycle with query_i high, the match result is registered.
  - hit_valid_r and hit_idx_r are updated, and is_a_pending_transaction_o is driven from hit_valid_r.
  - With query_i low, hit_valid_r and hit_idx_r keep their previous value.
- **Execute**
  - pending_transaction_executed_i with hit_valid_r set clears entry hit_idx_r and clears hit_valid_r.
  - Without hit_valid_r, the pulse only raises error_o; the table is unchanged.
- **Timeout**
  - Each valid entry's age increments per cycle, saturating.
  - When age reaches TIMEOUT_CYCLES-1, the entry is cleared and timeout_o pulses.
  - If several entries expire in the same cycle, all are cleared with a single timeout_o pulse.
  - The entry held in hit_idx_r while hit_valid_r is set is frozen: its age does not advance and it never expires.
- n_pending_o counts valid entries and is registered alongside the table.

## Timing
- Reset: all entries invalid; hit_valid_r = 0. Outputs: full_o = 0, is_a_pending_transaction_o = 0, timeout_o = 0, error_o = 0, n_pending_o = 0.
- Reset asserted mid-operation drops every entry immediately. No pulses are produced on reset release.
- Insert accepted in cycle N: entry visible to the match logic in N+1; n_pending_o and full_o updated in N+1.
- Query lookup latency is 1 cycle. query_i sampled in N gives is_a_pending_transaction_o valid in N+1.
- The consumer holds query fields stable until it samples the result.
- Lookups use registered state only. An entry inserted in cycle N does not hit a query in cycle N.
- Simultaneous events in one cycle:
  - Insert and execute both take effect.
  - full_o reflects the pre-edge state, so an insert while full is not accepted even if a slot frees in the same cycle.
  - Execute and query in the same cycle: the free uses the old hit_idx_r, and the new lookup excludes the freed entry.
- timeout_o and error_o are registered, asserted the cycle after the triggering edge, one cycle wide.

## Structure
- NIC-defines.v holds the field-width macros and a default `OTF_TABLE_ENTRIES.
- One sub-module: first_one, a parameterised lowest-set-bit priority encoder that returns index and found. It is instantiated twice: once on ~valid for allocation, once on the match vector for lookup.

## Test plan
- **Reset and single insert:** insert (sender 2, recipient 5, cmd 1) -> n_pending_o = 1 next cycle. Query of the same tuple -> is_a_pending_transaction_o = 1 one cycle later; a query with recipient 6 -> 0.
- **Fill to full:** 8 inserts -> full_o = 1 and n_pending_o = 8. A 9th insert is ignored. Execute on a hit -> full_o = 0 next cycle.
- **Duplicates:** two identical inserts land in slots 0 and 1. Query then execute -> slot 0 freed, n_pending_o 2 -> 1. A second query still hits.
- **Execute with no hit:** execute pulse after reset -> error_o one cycle, n_pending_o unchanged.
- **Timeout:** TIMEOUT_CYCLES = 16, insert -> timeout_o pulse and n_pending_o = 0 after 16 cycles. A hit-latched entry with no execute never times out.
- **Same-cycle events:** insert, execute and query in one cycle -> insert lands, freed entry gone, new query result excludes the entry inserted that cycle.
